psum_accum_drain: RTL and testbench

- Sits directly downstream of the 12x14 PE grid and consumes the 14 column partial sums it produces at the top of each column.
- Accumulates those sums over a configurable number of passes (one pass per input-channel or filter-row group).
- Then drains the 14 finished sums one column at a time over a valid/ready stream toward the output-feature-map buffer.

---
 rtl/psum_accum_drain.sv | 241 ++++++++++++++++++++++++
 tb/tb_psum_accum_drain.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_drain.sv
// psum_accum_drain
//   Collects the NUM_COLS column partial sums from the PE grid and accumulates
//   them over a programmable number of passes. It then streams the finished
//   sums out one column per cycle on a valid/ready interface.
//   Optional build macro PSUM_SAT_EN: accumulation saturates to the signed
//   ACC_W range and a sticky sat_flag output is added. Without the macro,
//   accumulation wraps modulo 2^ACC_W.
module psum_accum_drain #(
   parameter int NUM_COLS = 14,
   parameter int PSUM_W   = 32,
   parameter int ACC_W    = 32,
   parameter int PASS_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PASS_W-1:0]          num_passes,
   input  logic                       cap_valid,
   output logic                       cap_ready,
   input  logic [NUM_COLS*PSUM_W-1:0] psum_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_data,
   output logic [3:0]                 out_col,
   output logic                       out_last,
   output logic                       busy,
   output logic [PASS_W-1:0]          pass_idx
`ifdef PSUM_SAT_EN
   ,
   output logic                       sat_flag
`endif
);

   localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q [NUM_COLS];
   logic signed [ACC_W-1:0]   acc_d [NUM_COLS];
   logic signed [ACC_W-1:0]   lane_ext [NUM_COLS];
   logic [PASS_W-1:0]         pass_idx_q, pass_idx_d;
   logic [PASS_W-1:0]         target_q, target_d;
   logic                      out_valid_q, out_valid_d;
   logic [ACC_W-1:0]          out_data_q, out_data_d;
   logic [3:0]                out_col_q, out_col_d;
   logic                      out_last_q, out_last_d;
   logic [3:0]                col_nxt;
   logic [ACC_W-1:0]          next_col_data;
   logic                      capture;
`ifdef PSUM_SAT_EN
   logic                      sat_flag_q, sat_flag_d;
   logic [NUM_COLS-1:0]       lane_ovf;
`endif

`ifdef PSUM_SAT_EN
   // Signed overflow of a + b: operands share a sign that the sum does not.
   function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                    input logic signed [ACC_W-1:0] b);
      logic signed [ACC_W-1:0] s;
      s = a + b;
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction
`endif

   // Accumulator add: clamps to the signed range when saturation is built in,
   // otherwise a plain modulo-2^ACC_W sum.
   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
`ifdef PSUM_SAT_EN
      logic signed [ACC_W-1:0] s;
      s = a + b;
      if (add_ovf(a, b)) begin
         if (a[ACC_W-1]) return {1'b1, {(ACC_W-1){1'b0}}};
         else            return {1'b0, {(ACC_W-1){1'b1}}};
      end
      return s;
`else
      return a + b;
`endif
   endfunction

   assign capture   = cap_valid && cap_ready;
   assign cap_ready = (state_q != ST_DRAIN);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
   assign pass_idx  = pass_idx_q;
`ifdef PSUM_SAT_EN
   assign sat_flag  = sat_flag_q;
`endif

   // Sign-extend each incoming column psum to accumulator width.
   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) begin
         lane_ext[c] = ACC_W'($signed(psum_in[c*PSUM_W +: PSUM_W]));
      end
   end

   // Accumulator next state: the first pass of a group overwrites, later passes add.
   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) begin
         acc_d[c] = acc_q[c];
`ifdef PSUM_SAT_EN
         lane_ovf[c] = 1'b0;
`endif
         if (capture) begin
            if (state_q == ST_IDLE) begin
               acc_d[c] = lane_ext[c];
            end else begin
               acc_d[c] = acc_add(acc_q[c], lane_ext[c]);
`ifdef PSUM_SAT_EN
               lane_ovf[c] = add_ovf(acc_q[c], lane_ext[c]);
`endif
            end
         end
      end
   end

   // Select the accumulator for the column following the one being presented.
   always_comb begin
      col_nxt       = out_col_q + 4'd1;
      next_col_data = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (4'(c) == col_nxt) next_col_data = acc_q[c];
      end
   end

   // FSM next state and registered drain outputs.
   always_comb begin
      state_d     = state_q;
      pass_idx_d  = pass_idx_q;
      target_d    = target_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_col_d   = out_col_q;
      out_last_d  = out_last_q;
`ifdef PSUM_SAT_EN
      sat_flag_d  = sat_flag_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (capture) begin
               // A pass count of zero is treated as a single pass.
               target_d   = (num_passes == '0) ? PASS_W'(1) : num_passes;
               pass_idx_d = PASS_W'(1);
               if (target_d == PASS_W'(1)) begin
                  state_d     = ST_DRAIN;
                  out_valid_d = 1'b1;
                  out_col_d   = 4'd0;
                  out_data_d  = acc_d[0];
                  out_last_d  = (LAST_COL == 4'd0);
               end else begin
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            if (capture) begin
               pass_idx_d = pass_idx_q + PASS_W'(1);
`ifdef PSUM_SAT_EN
               sat_flag_d = sat_flag_q | (|lane_ovf);
`endif
               if (pass_idx_d == target_q) begin
                  // Column 0 is loaded straight from the final sum so it is
                  // visible the cycle after the last capture.
                  state_d     = ST_DRAIN;
                  out_valid_d = 1'b1;
                  out_col_d   = 4'd0;
                  out_data_d  = acc_d[0];
                  out_last_d  = (LAST_COL == 4'd0);
               end
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready) begin
               if (out_col_q == LAST_COL) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
                  out_col_d   = 4'd0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
                  pass_idx_d  = '0;
`ifdef PSUM_SAT_EN
                  sat_flag_d  = 1'b0;
`endif
               end else begin
                  out_col_d  = col_nxt;
                  out_data_d = next_col_data;
                  out_last_d = (col_nxt == LAST_COL);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers; asynchronous active-low reset aborts any group.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pass_idx_q  <= '0;
         target_q    <= PASS_W'(1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_col_q   <= 4'd0;
         out_last_q  <= 1'b0;
`ifdef PSUM_SAT_EN
         sat_flag_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pass_idx_q  <= pass_idx_d;
         target_q    <= target_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_col_q   <= out_col_d;
         out_last_q  <= out_last_d;
`ifdef PSUM_SAT_EN
         sat_flag_q  <= sat_flag_d;
`endif
      end
   end

   // Per-column accumulator bank.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_COLS; c++) acc_q[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_COLS; c++) acc_q[c] <= acc_d[c];
      end
   end

endmodule

// File: tb/tb_psum_accum_drain.sv
// Directed bench for psum_accum_drain (set PSUM_SAT_EN to exercise saturation).
module tb_psum_accum_drain;
   localparam int NC = 14;
   localparam int PW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       num_passes;
   logic             cap_valid;
   logic             cap_ready;
   logic [NC*PW-1:0] psum_in;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [3:0]       out_col;
   logic             out_last;
   logic             busy;
   logic [3:0]       pass_idx;
`ifdef PSUM_SAT_EN
   logic             sat_flag;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_data [NC];
   int          ec;

   psum_accum_drain #(.NUM_COLS(NC), .PSUM_W(PW), .ACC_W(32), .PASS_W(4)) dut (
      .clk(clk), .rst(rst), .num_passes(num_passes),
      .cap_valid(cap_valid), .cap_ready(cap_ready), .psum_in(psum_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_col(out_col), .out_last(out_last), .busy(busy), .pass_idx(pass_idx)
`ifdef PSUM_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int c, input logic [31:0] v);
      psum_in[c*PW +: PW] = v;
   endtask

   task automatic set_all(input logic [31:0] v);
      for (int c = 0; c < NC; c++) psum_in[c*PW +: PW] = v;
   endtask

   // Drains all columns with out_ready held high, checking each against exp_data.
   task automatic drain_all(input string tag);
      out_ready = 1'b1;
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("%s_valid_c%0d", tag, c), {31'd0, out_valid}, 32'd1);
         chk($sformatf("%s_col_c%0d", tag, c), {28'd0, out_col}, 32'(c));
         chk($sformatf("%s_data_c%0d", tag, c), out_data, exp_data[c]);
         chk($sformatf("%s_last_c%0d", tag, c), {31'd0, out_last}, (c == NC-1) ? 32'd1 : 32'd0);
         tick();
      end
      chk({tag, "_valid_end"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_capready_end"}, {31'd0, cap_ready}, 32'd1);
      chk({tag, "_passidx_end"}, {28'd0, pass_idx}, 32'd0);
   endtask

   initial begin
      rst        = 1'b0;
      num_passes = 4'd0;
      cap_valid  = 1'b0;
      out_ready  = 1'b0;
      psum_in    = '0;
      tick();
      tick();
      // Reset state
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_capready", {31'd0, cap_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_passidx", {28'd0, pass_idx}, 32'd0);
      chk("rst_col", {28'd0, out_col}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      rst = 1'b1;
      tick();

      // Single pass: lane 2 = 90
      num_passes = 4'd1;
      set_all(32'd0);
      set_lane(2, 32'd90);
      cap_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      cap_valid = 1'b0;
      chk("t1_passidx", {28'd0, pass_idx}, 32'd1);
      chk("t1_capready", {31'd0, cap_ready}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      for (int c = 0; c < NC; c++) exp_data[c] = (c == 2) ? 32'd90 : 32'd0;
      drain_all("t1");

      // Multi-pass: c+1, c+1, 10 -> 2c+12
      num_passes = 4'd3;
      for (int c = 0; c < NC; c++) set_lane(c, 32'(c + 1));
      cap_valid = 1'b1;
      tick();
      chk("t2_passidx1", {28'd0, pass_idx}, 32'd1);
      chk("t2_valid1", {31'd0, out_valid}, 32'd0);
      chk("t2_capready1", {31'd0, cap_ready}, 32'd1);
      chk("t2_busy1", {31'd0, busy}, 32'd1);
      num_passes = 4'd1;
      tick();
      chk("t2_passidx2", {28'd0, pass_idx}, 32'd2);
      chk("t2_valid2", {31'd0, out_valid}, 32'd0);
      set_all(32'd10);
      tick();
      cap_valid = 1'b0;
      chk("t2_capready_drain", {31'd0, cap_ready}, 32'd0);
      chk("t2_passidx3", {28'd0, pass_idx}, 32'd3);
      for (int c = 0; c < NC; c++) exp_data[c] = 32'(2*c + 12);
      drain_all("t2");

      // Backpressure: ready pattern 1,0,0,1 repeating
      num_passes = 4'd1;
      for (int c = 0; c < NC; c++) set_lane(c, 32'(c*7 - 20));
      cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
      ec = 0;
      for (int cyc = 0; cyc < 100 && ec < NC; cyc++) begin
         chk("t3_valid", {31'd0, out_valid}, 32'd1);
         chk("t3_col", {28'd0, out_col}, 32'(ec));
         chk("t3_data", out_data, 32'(ec*7 - 20));
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         tick();
         if (out_ready) ec++;
      end
      chk("t3_handshakes", 32'(ec), 32'd14);
      chk("t3_valid_end", {31'd0, out_valid}, 32'd0);
      chk("t3_busy_end", {31'd0, busy}, 32'd0);

      // Capture blocking: cap_valid held through drain, then overwrite
      num_passes = 4'd1;
      set_all(32'd5);
      cap_valid = 1'b1;
      tick();
      for (int c = 0; c < NC; c++) set_lane(c, 32'(1000 + c));
      for (int c = 0; c < NC; c++) exp_data[c] = 32'd5;
      drain_all("t4a");
      tick();
      cap_valid = 1'b0;
      chk("t4_recapture_valid", {31'd0, out_valid}, 32'd1);
      for (int c = 0; c < NC; c++) exp_data[c] = 32'(1000 + c);
      drain_all("t4b");

      // num_passes = 0 acts as 1; async reset mid-drain at col 5
      num_passes = 4'd0;
      set_all(32'hFFFF_FFFD);
      cap_valid = 1'b1;
      tick();
      cap_valid = 1'b0;
      chk("t5_np0_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_np0_data", out_data, 32'hFFFF_FFFD);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t5_col5", {28'd0, out_col}, 32'd5);
      out_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_rst_capready", {31'd0, cap_ready}, 32'd1);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_col", {28'd0, out_col}, 32'd0);
      chk("t5_rst_passidx", {28'd0, pass_idx}, 32'd0);
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("t5_post_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_post_capready", {31'd0, cap_ready}, 32'd1);
      num_passes = 4'd2;
      set_all(32'd1);
      cap_valid = 1'b1;
      tick();
      set_all(32'd2);
      tick();
      cap_valid = 1'b0;
      for (int c = 0; c < NC; c++) exp_data[c] = 32'd3;
      drain_all("t5");

      // Overflow on lane 0, positive
      num_passes = 4'd2;
      set_all(32'd0);
      set_lane(0, 32'h7FFF_FFFF);
      cap_valid = 1'b1;
      tick();
      tick();
      cap_valid = 1'b0;
      for (int c = 0; c < NC; c++) exp_data[c] = 32'd0;
`ifdef PSUM_SAT_EN
      exp_data[0] = 32'h7FFF_FFFF;
      chk("t6p_satflag", {31'd0, sat_flag}, 32'd1);
`else
      exp_data[0] = 32'hFFFF_FFFE;
`endif
      drain_all("t6p");
`ifdef PSUM_SAT_EN
      chk("t6p_satflag_clr", {31'd0, sat_flag}, 32'd0);
`endif

      // Overflow on lane 0, negative
      set_lane(0, 32'h8000_0000);
      cap_valid = 1'b1;
      tick();
      tick();
      cap_valid = 1'b0;
`ifdef PSUM_SAT_EN
      exp_data[0] = 32'h8000_0000;
      chk("t6n_satflag", {31'd0, sat_flag}, 32'd1);
`else
      exp_data[0] = 32'h0000_0000;
`endif
      drain_all("t6n");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
